// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop.
// TX_OUT, Busy and frame_done are registered from the next-state decode.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | start bit (low), bit counter cleared
// DATA   | shifting out data bits LSB-first
// PARITY | parity bit from external calculator
// STOP   | stop bit (high), frame_done asserted
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  par_bit,
    output logic                  par_load,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_par_en;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic [2:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_par_en_nxt;
    logic                  w_tx_nxt;
    logic                  w_accept;

    // Parity type only matters to the external calculator.
    logic w_unused_par_typ;
    assign w_unused_par_typ = PAR_TYP;

    assign w_accept = Data_Valid & (r_state == S_IDLE);
    assign par_load = w_accept & ~RST;

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_par_en_nxt = r_par_en;
        case (r_state)
            S_IDLE: begin
                if (Data_Valid) begin
                    w_state_nxt  = S_START;
                    w_shift_nxt  = P_DATA;
                    w_par_en_nxt = PAR_EN;
                end
            end
            S_START: begin
                w_state_nxt = S_DATA;
                w_cnt_nxt   = '0;
            end
            S_DATA: begin
                w_shift_nxt = r_shift >> 1;
                w_cnt_nxt   = r_cnt + 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Line value for the upcoming cycle, so the pin comes straight off a flop.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = par_bit;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_par_en <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_cnt    <= w_cnt_nxt;
            r_par_en <= w_par_en_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_STOP);
        end
    end

    assign TX_OUT     = r_tx;
    assign Busy       = r_busy;
    assign frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural parity calculator attached.
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       par_bit;
    logic       par_load;
    logic       TX_OUT;
    logic       Busy;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .par_bit    (par_bit),
        .par_load   (par_load),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .frame_done (frame_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // External parity calculator: even = XOR, odd = XNOR, captured on par_load.
    always @(posedge CLK or posedge RST) begin
        if (RST)           par_bit <= 1'b0;
        else if (par_load) par_bit <= PAR_TYP ? ^P_DATA : ~^P_DATA;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [11:0] frame;   // bit c = TX_OUT in cycle c after acceptance edge
        int          len;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s {tx,busy,done,load} got=%b want=%b", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Entered at edge+1 of the START cycle; leaves at edge+1 of the cycle after stop.
    // mode 1: scramble inputs every cycle; mode 2: switch P_DATA to late_data at cycle 3.
    task automatic run_frame(input string nm, input logic [11:0] frame, input int len,
                             input int mode, input logic [7:0] late_data, output int loads);
        loads = 0;
        for (int c = 0; c < len; c++) begin
            if (mode == 1) begin
                P_DATA  = ~P_DATA;
                PAR_EN  = ~PAR_EN;
                PAR_TYP = ~PAR_TYP;
            end else if (mode == 2 && c == 3) begin
                P_DATA = late_data;
            end
            #1;
            if (par_load) loads++;
            chk($sformatf("%s c%0d", nm, c), {TX_OUT, Busy, frame_done, par_load},
                {frame[c], 1'b1, (c == len - 1), 1'b0});
            @(posedge CLK);
            #1;
        end
    endtask

    int loads;
    int total_loads;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11};
        vecs[2] = '{8'h00, 1'b0, 1'b0, {2'b00, 1'b1, 8'h00, 1'b0}, 10};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 11};
        vecs[4] = '{8'h01, 1'b1, 1'b0, {1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11};
        vecs[5] = '{8'h07, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11};

        RST = 1'b1; Data_Valid = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset", {TX_OUT, Busy, frame_done, par_load}, 4'b1000);
        Data_Valid = 1'b1;
        #1;
        chk("reset dv", {TX_OUT, Busy, frame_done, par_load}, 4'b1000);
        Data_Valid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("idle", {TX_OUT, Busy, frame_done, par_load}, 4'b1000);

        for (int i = 0; i < 6; i++) begin
            P_DATA = vecs[i].data; PAR_EN = vecs[i].pe; PAR_TYP = vecs[i].pt;
            Data_Valid = 1'b1;
            #1;
            chk($sformatf("v%0d accept", i), {TX_OUT, Busy, frame_done, par_load}, 4'b1001);
            @(posedge CLK);
            #1;
            Data_Valid = 1'b0;
            run_frame($sformatf("v%0d", i), vecs[i].frame, vecs[i].len, 1, 8'h00, loads);
            chk($sformatf("v%0d idle", i), {TX_OUT, Busy, frame_done, par_load}, 4'b1000);
            @(posedge CLK);
            #1;
        end

        // Data_Valid held high: back-to-back frames with one idle cycle between.
        total_loads = 0;
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        #1;
        if (par_load) total_loads++;
        @(posedge CLK);
        #1;
        run_frame("held1", {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 2, 8'hFF, loads);
        total_loads += loads;
        if (par_load) total_loads++;
        chk("held gap", {TX_OUT, Busy, frame_done, par_load}, 4'b1001);
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        run_frame("held2", {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 0, 8'h00, loads);
        total_loads += loads;
        chk("held end", {TX_OUT, Busy, frame_done, par_load}, 4'b1000);
        chk_i("held loads", total_loads, 2);

        // Reset during the 4th data bit of 0x55, then a clean frame of 0x81.
        @(posedge CLK);
        #1;
        P_DATA = 8'h55; PAR_EN = 1'b0; Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rst55 c%0d", c), {TX_OUT, Busy, frame_done, par_load},
                {c == 0 ? 1'b0 : P_DATA[c - 1], 3'b100});
            @(posedge CLK);
            #1;
        end
        chk("rst55 bit3", {TX_OUT, Busy, frame_done, par_load}, 4'b0100);
        #2;
        RST = 1'b1;
        #1;
        chk("mid reset", {TX_OUT, Busy, frame_done, par_load}, 4'b1000);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        P_DATA = 8'h81; PAR_EN = 1'b0; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        #1;
        chk("post rst accept", {TX_OUT, Busy, frame_done, par_load}, 4'b1001);
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        run_frame("post rst", {2'b00, 1'b1, 8'h81, 1'b0}, 10, 0, 8'h00, loads);
        chk("post rst idle", {TX_OUT, Busy, frame_done, par_load}, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
